// File: rtl/mv_result_writer_if.sv
// rtl/mv_result_writer_if.sv - write port from the MV result writer to the result memory
interface mv_result_writer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [21:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_wr_en,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/mv_result_writer.sv
// rtl/mv_result_writer.sv - packs SAD compare results, buffers them and writes them to result memory
module mv_result_writer #(
  parameter int                BLK_COLS   = 4,
  parameter int                BLK_ROWS   = 4,
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h10,
  localparam int               NBLK       = BLK_COLS * BLK_ROWS,
  localparam int               CNT_W      = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pause,
  input  logic                frame_start,
  input  logic                res_valid,
  input  logic [3:0]          res_mv_x,
  input  logic [3:0]          res_mv_y,
  input  logic [13:0]         res_sad,
  mv_result_writer_if.master  mem,
  output logic                frame_done,
  output logic                overflow,
  output logic [CNT_W-1:0]    blk_count
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBLK - 1);

  typedef struct packed {
    logic [21:0]       wdata;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } entry_t;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t            state_q, state_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [CNT_W-1:0]  blk_count_q, blk_count_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [21:0]       mem_wdata_q, mem_wdata_d;

  logic [CNT_W-1:0]  blk_base;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic              more;
  entry_t            push_entry;
  entry_t            next_head;

  // Capture side: block index bookkeeping and the entry that would be pushed this cycle.
  always_comb begin
    blk_base         = frame_start ? '0 : blk_count_q;
    push_req         = res_valid & ~pause;
    push_entry.wdata = {res_sad, res_mv_y, res_mv_x};
    push_entry.addr  = BASE_ADDR + ADDR_W'(blk_base);
    push_entry.last  = (blk_base == LAST_IDX);
    blk_count_d      = blk_base;
    if (push_req) begin
      // Advance even when the entry is dropped so later addresses stay aligned.
      blk_count_d = (blk_base == LAST_IDX) ? '0 : blk_base + CNT_W'(1);
    end
  end

  // FIFO bookkeeping: the entry being written stays at the head until accepted.
  always_comb begin
    full         = (count_q == FULL_CNT);
    empty        = (count_q == '0);
    pop          = (state_q == S_WRITE) & mem.mem_ready;
    push_ok      = push_req & (~full | pop);
    more         = (count_q > ONE_CNT) | push_ok;
    // With a single entry left, the follow-on entry can only be the one arriving this edge.
    next_head    = (count_q > ONE_CNT) ? fifo_q[rd_ptr_q + PTR_W'(1)] : push_entry;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    overflow_d   = overflow_q | (push_req & full & ~pop);
    frame_done_d = pop & fifo_q[rd_ptr_q].last;
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_WRITE;
      S_WRITE: if (pop && !more) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Drain FSM outputs: load the head on entry to WRITE and after each accepted write.
  always_comb begin
    mem_wr_en_d = (state_d == S_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == S_IDLE && !empty) begin
      mem_addr_d  = fifo_q[rd_ptr_q].addr;
      mem_wdata_d = fifo_q[rd_ptr_q].wdata;
    end else if (pop && more) begin
      mem_addr_d  = next_head.addr;
      mem_wdata_d = next_head.wdata;
    end
  end

  // State, FIFO and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fifo_q       <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      blk_count_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      blk_count_q  <= blk_count_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem.mem_wr_en = mem_wr_en_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;
  assign blk_count     = blk_count_q;

endmodule
